load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 256, data-RAM size in bytes; addresses >= MEM_BYTES are out of range.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Req  input  1  request; sampled only when Ready=1.
REQ-005 Write  input  1  0 load, 1 store.
REQ-006 Size  input  2  00 byte, 01 half-word, 10 word, 11 illegal.
REQ-007 Signed  input  1  load extension: 1 sign-extend, 0 zero-extend.
REQ-008 Address  input  32  byte address, big-endian.
REQ-009 WrData  input  32  store data; byte uses [7:0], half uses [15:0].
REQ-010 Ready  output  1  high only in IDLE.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 RdData  output  32  extended load result, held until the next successful load.
REQ-013 MisalignErr  output  1  valid with Done; access was rejected.
REQ-014 MemEnable, MemReadWrite  output  1 each  to data RAM Enable and ReadWrite (1=write).
REQ-015 MemAddress  output  32, MemSize  output  2, MemDataIn  output  32  to data RAM.
REQ-016 MemDataOut  input  32  from data RAM; byte in [7:0], half in [15:0].

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS, DONE.
REQ-018 IDLE with Req=1: latch Write, Size, Signed, Address, WrData; go SETUP, or go DONE if rejected (REQ-025).
REQ-019 SETUP: drive MemAddress, MemSize, MemDataIn, MemReadWrite from latched request; MemEnable=0; go ACCESS.
REQ-020 ACCESS: MemEnable=1 for exactly one cycle; loads capture MemDataOut into RdData at the ending edge; go DONE.
REQ-021 DONE: Done=1, MemEnable=0; go IDLE; Req in DONE is ignored.
REQ-022 Latency: request accepted at cycle N gives Done at N+3; the next request can be accepted at N+4.
REQ-023 MemAddress, MemSize, MemReadWrite, and MemDataIn change only while MemEnable=0.
REQ-024 Load extension: byte gives {24 x bit7 or 0, [7:0]}; half gives {16 x bit15 or 0, [15:0]}; word passes through unchanged.
REQ-025 Reject (only when checking is compiled in): Size=11, half at odd address, word with Address%4!=0, or Address+bytes>MEM_BYTES.
REQ-026 On reject: go IDLE->DONE directly (Done at N+1), MisalignErr=1 for that cycle, MemEnable never asserted, RdData unchanged.
REQ-027 Stores leave RdData unchanged; MisalignErr=0 on every successful completion.

Reset
REQ-028 Reset=1 at an edge forces IDLE and abandons any in-flight access without Done; the same edge resets MemEnable, MemReadWrite, MemAddress, MemSize, MemDataIn, RdData, Done, and MisalignErr to 0; Ready=1.
REQ-029 Reset has priority over Req in the same cycle.

Configuration
REQ-030 LSU_ALIGN_CHECK_EN defined: REQ-025/026 active.
REQ-031 LSU_ALIGN_CHECK_EN undefined: MisalignErr tied 0, every request takes the SETUP/ACCESS path, and Size=11 is passed to the RAM unchanged.

Structure
REQ-032 Package lsu_pkg holds the SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings and the FSM state type.
REQ-033 One sub-module, lsu_load_extend, is combinational: it takes MemDataOut, Size, and Signed and produces the extended word.

Verification (RAM preloaded Mem[0..3]=80,01,FF,7F hex)
REQ-034 Word load at address 0, Req at N -> Done at N+3, RdData=32'h8001FF7F, MemEnable high exactly one cycle.
REQ-035 Byte load at address 0 with Signed=1 -> RdData=32'hFFFFFF80; with Signed=0 -> RdData=32'h00000080.
REQ-036 Half store at address 2 with WrData=32'h0000D3A5, then word load at address 0 -> RdData=32'h8001D3A5.
REQ-037 With the macro, word load at address 6 -> Done at N+1, MisalignErr=1, MemEnable stays 0, RdData unchanged.
REQ-038 Reset asserted during ACCESS -> next cycle IDLE, Ready=1, no Done, all outputs 0.
REQ-039 Req held high continuously -> requests accepted at N and N+4 only; Req during DONE is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type and the request rejection rule used when alignment
// checking is compiled in (LSU_ALIGN_CHECK_EN).
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

  // True when a request must be refused: illegal size, misaligned
  // half/word, or any byte of the access beyond the end of the RAM.
  // The end address is formed in 33 bits so addresses near 2^32 cannot wrap.
  function automatic logic access_rejected(input logic [1:0]  size,
                                           input logic [31:0] addr,
                                           input logic [32:0] mem_bytes);
    logic [32:0] end_addr;
    end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
    access_rejected = (size == SIZE_ILL)
                   || ((size == SIZE_HALF) && addr[0])
                   || ((size == SIZE_WORD) && (addr[1:0] != 2'b00))
                   || (end_addr > mem_bytes);
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load extension: selects the valid low-order bytes of the
// RAM read data and sign- or zero-extends them to 32 bits.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] mem_data_out,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ext_data
);

  logic byte_fill;
  logic half_fill;

  assign byte_fill = is_signed & mem_data_out[7];
  assign half_fill = is_signed & mem_data_out[15];

  // Byte and half results are widened; word (and the unchecked illegal
  // size) passes the RAM data straight through.
  always_comb begin
    ext_data = mem_data_out;
    case (size)
      SIZE_BYTE: ext_data = {{24{byte_fill}}, mem_data_out[7:0]};
      SIZE_HALF: ext_data = {{16{half_fill}}, mem_data_out[15:0]};
      default:   ext_data = mem_data_out;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word request at a time and runs
// it through SETUP (RAM controls settle with enable low), ACCESS (one
// enable cycle) and DONE (completion pulse).
// Optional feature: define LSU_ALIGN_CHECK_EN to refuse illegal sizes,
// misaligned and out-of-range accesses (completes at once with
// misalign_err=1 and no RAM cycle). Without it misalign_err is tied 0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  output logic        ready,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        misalign_err,
  output logic        mem_enable,
  output logic        mem_read_write,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  lsu_state_t  state_reg;
  logic        ready_reg;
  logic        done_reg;
  logic        misalign_reg;
  logic        mem_enable_reg;
  logic        mem_read_write_reg;
  logic [31:0] mem_address_reg;
  logic [1:0]  mem_size_reg;
  logic [31:0] mem_data_in_reg;
  logic        signed_reg;
  logic [31:0] rd_data_reg;
  logic [31:0] ext_data;
  logic        reject;

`ifdef LSU_ALIGN_CHECK_EN
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  // Decision taken on the incoming (not yet latched) request in IDLE.
  assign reject       = access_rejected(size, address, MEM_LIMIT);
  assign misalign_err = misalign_reg;
`else
  assign reject       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  lsu_load_extend u_load_extend (
    .mem_data_out (mem_data_out),
    .size         (mem_size_reg),
    .is_signed    (signed_reg),
    .ext_data     (ext_data)
  );

  // Request sequencer; all outputs are registers updated on the
  // transition into the state in which they must be valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      ready_reg          <= 1'b1;
      done_reg           <= 1'b0;
      misalign_reg       <= 1'b0;
      mem_enable_reg     <= 1'b0;
      mem_read_write_reg <= 1'b0;
      mem_address_reg    <= 32'd0;
      mem_size_reg       <= 2'd0;
      mem_data_in_reg    <= 32'd0;
      signed_reg         <= 1'b0;
      rd_data_reg        <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            ready_reg <= 1'b0;
            if (reject) begin
              // Refused: skip the RAM entirely and complete next cycle.
              state_reg    <= ST_DONE;
              done_reg     <= 1'b1;
              misalign_reg <= 1'b1;
            end else begin
              // RAM controls are set here so they are stable through
              // SETUP and ACCESS and only move while enable is low.
              state_reg          <= ST_SETUP;
              mem_read_write_reg <= write;
              mem_address_reg    <= address;
              mem_size_reg       <= size;
              mem_data_in_reg    <= wr_data;
              signed_reg         <= is_signed;
            end
          end
        end
        ST_SETUP: begin
          state_reg      <= ST_ACCESS;
          mem_enable_reg <= 1'b1;
        end
        ST_ACCESS: begin
          state_reg      <= ST_DONE;
          mem_enable_reg <= 1'b0;
          done_reg       <= 1'b1;
          if (!mem_read_write_reg) begin
            rd_data_reg <= ext_data;
          end
        end
        ST_DONE: begin
          state_reg    <= ST_IDLE;
          done_reg     <= 1'b0;
          misalign_reg <= 1'b0;
          ready_reg    <= 1'b1;
        end
        default: begin
          state_reg      <= ST_IDLE;
          ready_reg      <= 1'b1;
          done_reg       <= 1'b0;
          misalign_reg   <= 1'b0;
          mem_enable_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ready          = ready_reg;
  assign done           = done_reg;
  assign rd_data        = rd_data_reg;
  assign mem_enable     = mem_enable_reg;
  assign mem_read_write = mem_read_write_reg;
  assign mem_address    = mem_address_reg;
  assign mem_size       = mem_size_reg;
  assign mem_data_in    = mem_data_in_reg;

endmodule
